// File: rtl/mpsoc_pl_gpio_bram_slave.sv
// mpsoc_pl_gpio_bram_slave
// AXI4-Lite slave for the PL side of the MPSoC base design. It decodes two
// 64 KB windows behind the PS general-purpose master port:
//   0xA000_xxxx : LED GPIO data register (aliased across the window)
//   0xA001_xxxx : word-addressed block RAM (index aliases inside the window)
// Any other address is unmapped: writes are dropped, reads return zero, and
// both respond with DECERR.
//
// Ports
//   ACLK, ARESETn        clock, asynchronous active-low reset
//   S_AXI_AW*/W*/B*      write address / data / response channels
//   S_AXI_AR*/R*         read address / data channels
//   app_leds_tri_o       GPIO data register, straight from the flops
//
// One write and one read may be outstanding at a time. The read and write
// paths are independent of each other.
module mpsoc_pl_gpio_bram_slave #(
  parameter int BRAM_WORDS = 1024,
  parameter int LED_WIDTH  = 4
) (
  input  logic                 ACLK,
  input  logic                 ARESETn,
  input  logic [31:0]          S_AXI_AWADDR,
  input  logic                 S_AXI_AWVALID,
  output logic                 S_AXI_AWREADY,
  input  logic [31:0]          S_AXI_WDATA,
  input  logic [3:0]           S_AXI_WSTRB,
  input  logic                 S_AXI_WVALID,
  output logic                 S_AXI_WREADY,
  output logic [1:0]           S_AXI_BRESP,
  output logic                 S_AXI_BVALID,
  input  logic                 S_AXI_BREADY,
  input  logic [31:0]          S_AXI_ARADDR,
  input  logic                 S_AXI_ARVALID,
  output logic                 S_AXI_ARREADY,
  output logic [31:0]          S_AXI_RDATA,
  output logic [1:0]           S_AXI_RRESP,
  output logic                 S_AXI_RVALID,
  input  logic                 S_AXI_RREADY,
  output logic [LED_WIDTH-1:0] app_leds_tri_o
);

  localparam int IDX_W = (BRAM_WORDS > 1) ? $clog2(BRAM_WORDS) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {REGION_NONE, REGION_GPIO, REGION_BRAM} region_t;
  typedef enum logic {W_IDLE, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  function automatic region_t decode(input logic [31:0] addr);
    region_t r;
    case (addr[31:16])
      16'hA000: r = REGION_GPIO;
      16'hA001: r = REGION_BRAM;
      default:  r = REGION_NONE;
    endcase
    return r;
  endfunction

  // Ready outputs stay low while in reset and rise on the first edge after it.
  logic ready_en;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    // NOTE: clocked state uses non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of block ordering.
    if (!ARESETn) ready_en <= 1'b0;
    else          ready_en <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Write path
  // ---------------------------------------------------------------------------
  w_state_t    w_state, w_state_n;
  logic        aw_held, w_held;
  logic [31:0] aw_addr_q, w_data_q;
  logic [3:0]  w_strb_q;
  logic        aw_hs, w_hs, commit;
  logic [31:0] wr_addr, wr_data;
  logic [3:0]  wr_strb;
  region_t     wr_region;
  logic [1:0]  bresp_q;
  logic [LED_WIDTH-1:0] leds_q;

  assign aw_hs = S_AXI_AWVALID && S_AXI_AWREADY;
  assign w_hs  = S_AXI_WVALID && S_AXI_WREADY;

  // A beat captured on an earlier edge comes from the holding register; a beat
  // arriving on this edge is used directly, so the commit happens on the edge
  // where the later of the two beats is accepted.
  assign wr_addr   = aw_held ? aw_addr_q : S_AXI_AWADDR;
  assign wr_data   = w_held  ? w_data_q  : S_AXI_WDATA;
  assign wr_strb   = w_held  ? w_strb_q  : S_AXI_WSTRB;
  assign wr_region = decode(wr_addr);

  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no
    // path through the case leaves a value unassigned and infers a latch.
    w_state_n     = w_state;
    commit        = 1'b0;
    S_AXI_AWREADY = 1'b0;
    S_AXI_WREADY  = 1'b0;
    S_AXI_BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        S_AXI_AWREADY = ready_en && !aw_held;
        S_AXI_WREADY  = ready_en && !w_held;
        if ((aw_held || aw_hs) && (w_held || w_hs)) begin
          commit    = 1'b1;
          w_state_n = W_RESP;
        end
      end
      W_RESP: begin
        S_AXI_BVALID = 1'b1;
        if (S_AXI_BREADY) w_state_n = W_IDLE;
      end
      default: w_state_n = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state   <= W_IDLE;
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state <= w_state_n;
      if (commit) begin
        aw_held <= 1'b0;
        w_held  <= 1'b0;
        bresp_q <= (wr_region == REGION_NONE) ? RESP_DECERR : RESP_OKAY;
      end else begin
        if (aw_hs) begin
          aw_held   <= 1'b1;
          aw_addr_q <= S_AXI_AWADDR;
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= S_AXI_WDATA;
          w_strb_q <= S_AXI_WSTRB;
        end
      end
    end
  end

  assign S_AXI_BRESP = bresp_q;

  // GPIO data register: each stored bit follows the strobe of its byte lane.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      leds_q <= '0;
    end else if (commit && wr_region == REGION_GPIO) begin
      for (int i = 0; i < LED_WIDTH; i++) begin
        if (wr_strb[i/8]) leds_q[i] <= wr_data[i];
      end
    end
  end

  assign app_leds_tri_o = leds_q;

  // ---------------------------------------------------------------------------
  // Read path
  // ---------------------------------------------------------------------------
  r_state_t             r_state, r_state_n;
  logic                 ar_hs;
  region_t              rd_region, rsel_q;
  logic [1:0]           rresp_q;
  logic [LED_WIDTH-1:0] gpio_rd_q;
  logic [31:0]          ram_q;

  assign ar_hs     = S_AXI_ARVALID && S_AXI_ARREADY;
  assign rd_region = decode(S_AXI_ARADDR);

  always_comb begin
    r_state_n     = r_state;
    S_AXI_ARREADY = 1'b0;
    S_AXI_RVALID  = 1'b0;
    case (r_state)
      R_IDLE: begin
        S_AXI_ARREADY = ready_en;
        if (ar_hs) r_state_n = R_DATA;
      end
      R_DATA: begin
        S_AXI_RVALID = 1'b1;
        if (S_AXI_RREADY) r_state_n = R_IDLE;
      end
      default: r_state_n = R_IDLE;
    endcase
  end

  // Read-side registers only load on an AR handshake, which can only happen in
  // R_IDLE, so RDATA/RRESP stay frozen while a response waits for RREADY.
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state   <= R_IDLE;
      rsel_q    <= REGION_NONE;
      rresp_q   <= RESP_OKAY;
      gpio_rd_q <= '0;
    end else begin
      r_state <= r_state_n;
      if (ar_hs) begin
        rsel_q    <= rd_region;
        rresp_q   <= (rd_region == REGION_NONE) ? RESP_DECERR : RESP_OKAY;
        gpio_rd_q <= leds_q;
      end
    end
  end

  // Block RAM: byte-masked write port plus registered read port. Both sample
  // the array before the edge, so a same-word collision returns the old data.
  logic [31:0] mem [BRAM_WORDS];

  always_ff @(posedge ACLK) begin
    // NOTE: the array and its read register carry no reset so the tools can map
    // them onto block RAM; the contents are undefined until written.
    if (commit && wr_region == REGION_BRAM) begin
      for (int b = 0; b < 4; b++) begin
        if (wr_strb[b]) mem[wr_addr[IDX_W+1:2]][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
    if (ar_hs && rd_region == REGION_BRAM) ram_q <= mem[S_AXI_ARADDR[IDX_W+1:2]];
  end

  always_comb begin
    case (rsel_q)
      REGION_GPIO: S_AXI_RDATA = 32'(gpio_rd_q);
      REGION_BRAM: S_AXI_RDATA = ram_q;
      default:     S_AXI_RDATA = 32'h0;
    endcase
  end

  assign S_AXI_RRESP = rresp_q;

  // Low address bits outside the word index are don't-care by design.
  logic unused_addr_bits;
  assign unused_addr_bits = ^{wr_addr[15:0], S_AXI_ARADDR[15:0]};

endmodule

// File: tb/tb_mpsoc_pl_gpio_bram_slave.sv
// Testbench for mpsoc_pl_gpio_bram_slave. Directed AXI4-Lite transactions with
// a reference model of the LED register and RAM; expected responses go into
// scoreboard queues when a transaction is issued and are popped when the DUT
// presents the matching B or R beat.
module tb_mpsoc_pl_gpio_bram_slave;

  localparam int BRAM_WORDS = 1024;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] DECERR = 2'b11;

  logic        ACLK = 1'b0;
  logic        ARESETn = 1'b0;
  logic [31:0] S_AXI_AWADDR = '0;
  logic        S_AXI_AWVALID = 1'b0;
  logic        S_AXI_AWREADY;
  logic [31:0] S_AXI_WDATA = '0;
  logic [3:0]  S_AXI_WSTRB = '0;
  logic        S_AXI_WVALID = 1'b0;
  logic        S_AXI_WREADY;
  logic [1:0]  S_AXI_BRESP;
  logic        S_AXI_BVALID;
  logic        S_AXI_BREADY = 1'b0;
  logic [31:0] S_AXI_ARADDR = '0;
  logic        S_AXI_ARVALID = 1'b0;
  logic        S_AXI_ARREADY;
  logic [31:0] S_AXI_RDATA;
  logic [1:0]  S_AXI_RRESP;
  logic        S_AXI_RVALID;
  logic        S_AXI_RREADY = 1'b0;
  logic [3:0]  app_leds_tri_o;

  mpsoc_pl_gpio_bram_slave #(.BRAM_WORDS(BRAM_WORDS), .LED_WIDTH(4)) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB), .S_AXI_WVALID(S_AXI_WVALID),
    .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP), .S_AXI_RVALID(S_AXI_RVALID),
    .S_AXI_RREADY(S_AXI_RREADY),
    .app_leds_tri_o(app_leds_tri_o)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    logic [31:0] data;
    logic [1:0]  resp;
  } rd_exp_t;

  rd_exp_t     rq[$];
  logic [1:0]  bq[$];
  logic [3:0]  leds_m = 4'h0;
  logic [31:0] mem_m [int];

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int region(input logic [31:0] a);
    if (a[31:16] == 16'hA000) return 1;
    if (a[31:16] == 16'hA001) return 2;
    return 0;
  endfunction

  // Update the model, push the expected BRESP, then run the handshakes.
  // W is presented w_lead cycles before AW; BREADY is held low for b_stall
  // cycles once BVALID is up; take_resp=0 leaves the response pending.
  task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int w_lead, input int b_stall, input bit take_resp);
    int          cyc;
    bit          aw_done, w_done, aw_fire, w_fire;
    int          idx;
    logic [31:0] word;
    logic [1:0]  exp_resp;
    case (region(a))
      1: begin
        for (int i = 0; i < 4; i++) if (s[0]) leds_m[i] = d[i];
        bq.push_back(OKAY);
      end
      2: begin
        idx  = int'(a[11:2]);
        word = mem_m.exists(idx) ? mem_m[idx] : 32'h0;
        for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = d[8*b +: 8];
        mem_m[idx] = word;
        bq.push_back(OKAY);
      end
      default: bq.push_back(DECERR);
    endcase

    S_AXI_AWADDR = a;
    S_AXI_WDATA  = d;
    S_AXI_WSTRB  = s;
    aw_done = 1'b0;
    w_done  = 1'b0;
    cyc     = 0;
    while (!(aw_done && w_done) && cyc < 40) begin
      @(negedge ACLK);
      if (w_done && !aw_done) check("no_commit_before_aw", S_AXI_BVALID, 1'b0);
      S_AXI_AWVALID = !aw_done && (cyc >= w_lead);
      S_AXI_WVALID  = !w_done;
      aw_fire = S_AXI_AWVALID && S_AXI_AWREADY;
      w_fire  = S_AXI_WVALID && S_AXI_WREADY;
      @(posedge ACLK);
      if (aw_fire) aw_done = 1'b1;
      if (w_fire)  w_done  = 1'b1;
      cyc++;
    end
    @(negedge ACLK);
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    check("write_handshake", {aw_done, w_done}, 2'b11);
    check("leds_after_write", app_leds_tri_o, leds_m);
    check("bvalid_latency", S_AXI_BVALID, 1'b1);
    if (take_resp) begin
      for (int k = 0; k < b_stall; k++) begin
        @(negedge ACLK);
        check("bvalid_held", S_AXI_BVALID, 1'b1);
        check("bresp_held", S_AXI_BRESP, bq[0]);
        check("awready_in_resp", S_AXI_AWREADY, 1'b0);
      end
      S_AXI_BREADY = 1'b1;
      exp_resp = bq.pop_front();
      check("bresp", S_AXI_BRESP, exp_resp);
      @(negedge ACLK);
      S_AXI_BREADY = 1'b0;
      check("bvalid_cleared", S_AXI_BVALID, 1'b0);
    end
  endtask

  // Push the expected R beat from the model, then run AR and R with RREADY held
  // low for r_stall cycles after RVALID rises.
  task automatic axi_read(input logic [31:0] a, input int r_stall);
    int      cyc;
    bit      done, fire;
    rd_exp_t e;
    case (region(a))
      1:       begin e.data = {28'h0, leds_m};          e.resp = OKAY;   end
      2:       begin e.data = mem_m[int'(a[11:2])];     e.resp = OKAY;   end
      default: begin e.data = 32'h0;                    e.resp = DECERR; end
    endcase
    rq.push_back(e);

    S_AXI_ARADDR = a;
    done = 1'b0;
    cyc  = 0;
    while (!done && cyc < 40) begin
      @(negedge ACLK);
      S_AXI_ARVALID = 1'b1;
      fire = S_AXI_ARREADY;
      @(posedge ACLK);
      done = fire;
      cyc++;
    end
    @(negedge ACLK);
    S_AXI_ARVALID = 1'b0;
    check("read_handshake", done, 1'b1);
    check("rvalid_latency", S_AXI_RVALID, 1'b1);
    for (int k = 0; k < r_stall; k++) begin
      @(negedge ACLK);
      check("rvalid_held", S_AXI_RVALID, 1'b1);
      check("rdata_held", S_AXI_RDATA, rq[0].data);
      check("arready_in_data", S_AXI_ARREADY, 1'b0);
    end
    S_AXI_RREADY = 1'b1;
    e = rq.pop_front();
    check("rdata", S_AXI_RDATA, e.data);
    check("rresp", S_AXI_RRESP, e.resp);
    @(negedge ACLK);
    S_AXI_RREADY = 1'b0;
    check("rvalid_cleared", S_AXI_RVALID, 1'b0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for 20 cycles.
    ARESETn = 1'b0;
    repeat (20) @(negedge ACLK);
    check("reset_leds", app_leds_tri_o, 4'h0);
    check("reset_bvalid", S_AXI_BVALID, 1'b0);
    check("reset_rvalid", S_AXI_RVALID, 1'b0);
    check("reset_rdata", S_AXI_RDATA, 32'h0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("awready_after_reset", S_AXI_AWREADY, 1'b1);
    check("wready_after_reset", S_AXI_WREADY, 1'b1);
    check("arready_after_reset", S_AXI_ARREADY, 1'b1);

    // GPIO: only the low four bits are stored; reads are zero-extended.
    axi_write(32'hA000_0000, 32'hFFFF_FFFF, 4'hF, 0, 0, 1'b1);
    axi_read(32'hA000_0000, 0);

    // BRAM full-word write and read-back, with stalled B and R channels.
    axi_write(32'hA001_0000, 32'hDEAD_BEEF, 4'hF, 0, 5, 1'b1);
    axi_read(32'hA001_0000, 5);

    // Byte strobe, then index aliasing one full RAM depth higher.
    axi_write(32'hA001_0000, 32'h0000_00AA, 4'b0001, 0, 0, 1'b1);
    axi_read(32'hA001_0000, 0);
    axi_read(32'hA001_0000 + 4 * BRAM_WORDS, 0);

    // Unmapped: write dropped with DECERR, read returns zero with DECERR.
    axi_write(32'hA002_0000, 32'h1234_5678, 4'hF, 0, 0, 1'b1);
    axi_read(32'hA001_0000, 0);
    axi_read(32'hA000_0000, 0);
    axi_read(32'hA002_0000, 2);

    // W beat three cycles ahead of AW produces exactly one commit.
    axi_write(32'hA001_0010, 32'h0BAD_F00D, 4'hF, 3, 0, 1'b1);
    axi_read(32'hA001_0010, 0);

    // GPIO aliasing across the window, and an all-zero strobe leaving it alone.
    axi_write(32'hA000_0104, 32'h0000_0005, 4'b0001, 0, 0, 1'b1);
    axi_read(32'hA000_FFFC, 0);
    axi_write(32'hA000_0000, 32'h0000_000A, 4'b0000, 0, 0, 1'b1);
    axi_read(32'hA000_0008, 1);

    // Reset pulsed while the write response is pending.
    axi_write(32'hA000_0000, 32'h0000_000A, 4'hF, 0, 0, 1'b0);
    @(negedge ACLK);
    check("bvalid_pending", S_AXI_BVALID, 1'b1);
    ARESETn = 1'b0;
    #1;
    check("reset_in_resp_bvalid", S_AXI_BVALID, 1'b0);
    check("reset_in_resp_leds", app_leds_tri_o, 4'h0);
    bq.delete();
    leds_m = 4'h0;
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check("awready_after_pulse", S_AXI_AWREADY, 1'b1);
    check("wready_after_pulse", S_AXI_WREADY, 1'b1);
    axi_read(32'hA000_0000, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mpsoc_pl_gpio_bram_slave.md
# mpsoc_pl_gpio_bram_slave

AXI4-Lite slave subsystem for the programmable-logic side of the MPSoC base design. The processing system's general-purpose master port drives it. It decodes two 64 KB windows: a 4-bit LED GPIO at 0xA000_0000 and a word-addressed block RAM at 0xA001_0000. It sits directly behind the PS master port, and its LED outputs go to board pins.

## Interface
Parameters:
- BRAM_WORDS, 1024: RAM depth in 32-bit words; power of two, at most 16384.
- LED_WIDTH, 4: GPIO output width, from 1 to 32.

Ports:
- ACLK  in  1  single clock; all logic on rising edge.
- ARESETn  in  1  asynchronous, active-low reset; deassertion must be synchronous to ACLK upstream.
- S_AXI_AWADDR  in  32, S_AXI_AWVALID in 1, S_AXI_AWREADY out 1  write address channel.
- S_AXI_WDATA  in  32, S_AXI_WSTRB in 4, S_AXI_WVALID in 1, S_AXI_WREADY out 1  write data channel.
- S_AXI_BRESP  out  2, S_AXI_BVALID out 1, S_AXI_BREADY in 1  write response channel.
- S_AXI_ARADDR  in  32, S_AXI_ARVALID in 1, S_AXI_ARREADY out 1  read address channel.
- S_AXI_RDATA  out  32, S_AXI_RRESP out 2, S_AXI_RVALID out 1, S_AXI_RREADY in 1  read data channel.
- app_leds_tri_o  out  LED_WIDTH  GPIO data register output to the LEDs.

## Operation
Address decode uses ADDR[31:16]:
- 0xA000 selects the GPIO.
- 0xA001 selects the BRAM.
- Any other value is unmapped.
- ADDR[1:0] are ignored in every region.

GPIO:
- One data register, readable and writable at every word offset in the window; it aliases across the window.
- Bytes are written per WSTRB; only bits [LED_WIDTH-1:0] are stored.
- Reads return the register zero-extended to 32 bits.
- app_leds_tri_o is the register value, driven combinationally from the flop.

BRAM:
- Word index is ADDR[log2(BRAM_WORDS)+1:2]; higher offset bits inside the window alias.
- Writes are byte-masked by WSTRB.
- Contents are not reset; they are undefined until written.

Unmapped accesses:
- Writes are discarded.
- Reads return 0x0000_0000.
- Both respond with DECERR (2'b11). Mapped accesses respond OKAY (2'b00).

Write FSM (W_IDLE, W_RESP):
- In W_IDLE, AWREADY and WREADY are each 1 until their own beat is captured. AW and W may arrive in either order or together.
- When both beats are held, the write commits on that edge. BVALID asserts the next cycle and the FSM enters W_RESP.
- In W_RESP, AWREADY=WREADY=0. On BVALID&&BREADY the FSM returns to W_IDLE.

Read FSM (R_IDLE, R_DATA):
- In R_IDLE, ARREADY=1. On the AR handshake the synchronous RAM read (or GPIO read) is registered.
- RVALID asserts the next cycle with RDATA/RRESP; the FSM enters R_DATA with ARREADY=0.
- RDATA/RRESP hold stable while RVALID&&!RREADY.
- On RVALID&&RREADY the FSM returns to R_IDLE.

Collisions: a read and a write to the same BRAM word on the same edge is read-first; the read returns the old data. A GPIO write committing on the same edge as a GPIO read capture likewise returns the old value.

## Timing
- Reset values, asserted asynchronously:
  - app_leds_tri_o=0; BVALID=0, RVALID=0, BRESP=0, RRESP=0, RDATA=0.
  - AWREADY=WREADY=ARREADY=1 from the first edge after deassertion.
  - Both FSMs return to idle.
  - Reset mid-transaction drops any pending beats and responses; no write commits.
- Write latency: the write commits on the edge where the last of AW/W is captured. BVALID follows 1 cycle later; app_leds_tri_o updates on that commit edge.
- Read latency: RVALID follows the AR handshake by 1 cycle.
- Throughput: at most one outstanding read and one outstanding write; the read and write paths are fully independent.
- BREADY or RREADY held low stalls the channel indefinitely; no new address is accepted on that channel meanwhile.

## Test plan
- Reset: hold ARESETn low for 20 cycles -> leds=4'h0, BVALID=RVALID=0; after release, AWREADY=WREADY=ARREADY=1.
- GPIO: write 0xA000_0000 data 0xFFFF_FFFF strb 4'hF -> leds=4'hF, BRESP=OKAY. Read 0xA000_0000 -> 0x0000_000F, OKAY.
- BRAM: write 0xA001_0000 data 0xDEAD_BEEF -> OKAY. Read back -> 0xDEAD_BEEF, OKAY.
- Strobes and aliasing: write 0x0000_00AA strb 4'b0001 to 0xA001_0000 -> read 0xDEAD_BEAA. Read 0xA001_0000+4*BRAM_WORDS -> same word.
- Unmapped: write 0xA002_0000 -> BRESP=DECERR, BRAM/GPIO unchanged. Read 0xA002_0000 -> 0x0, RRESP=DECERR.
- Handshake stress:
  - W beat 3 cycles before AW -> single commit.
  - BREADY/RREADY low 5 cycles -> outputs held stable.
  - ARESETn pulsed during W_RESP -> BVALID=0, leds=0.
